// File: rtl/mat_row_server.sv
// mat_row_server: row store of SIZE rows x SIZE complex elements that serves
// whole-row read requests through a three-state FETCH pipeline.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   ld_row_i/ld_addr_i     row data and row index to store
//   ld_valid_i/ld_ready_o  load handshake; ready is low only while flushing
//   req_addr_i/req_valid_i requested row; valid held until the response
//   mat_row_o              returned row, held between responses
//   mat_row_addr_o         index of the returned row
//   mat_row_valid_o        one-cycle response strobe
//   loaded_o               per-row loaded bitmap
//   flush_i                abort in-flight request and clear loaded_o
//   busy_o                 request in flight (FETCH or RESP)
module mat_row_server #(
   parameter int SIZE   = 16,
   parameter int ELEM_W = 128,
   parameter int AW     = $clog2(SIZE)
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [SIZE*ELEM_W-1:0] ld_row_i,
   input  logic [AW-1:0]          ld_addr_i,
   input  logic                   ld_valid_i,
   output logic                   ld_ready_o,
   input  logic [AW-1:0]          req_addr_i,
   input  logic                   req_valid_i,
   output logic [SIZE*ELEM_W-1:0] mat_row_o,
   output logic [AW-1:0]          mat_row_addr_o,
   output logic                   mat_row_valid_o,
   output logic [SIZE-1:0]        loaded_o,
   input  logic                   flush_i,
   output logic                   busy_o
);

   localparam int ROW_W = SIZE * ELEM_W;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      RESP
   } state_e;

   state_e             state_q, state_d;
   logic [ROW_W-1:0]   mem_q [SIZE];
   logic [SIZE-1:0]    loaded_q, loaded_d;
   logic [AW-1:0]      addr_q, addr_d;
   logic [AW-1:0]      row_addr_q, row_addr_d;
   logic [ROW_W-1:0]   row_q, row_d;
   logic               ld_fire;

   assign ld_ready_o      = !flush_i;
   assign ld_fire         = ld_valid_i && !flush_i;
   assign mat_row_o       = row_q;
   assign mat_row_addr_o  = row_addr_q;
   assign mat_row_valid_o = (state_q == RESP);
   assign busy_o          = (state_q != IDLE);
   assign loaded_o        = loaded_q;

   // Storage is deliberately not reset. The FETCH read samples mem_q before
   // this edge's write lands, so a same-edge load to the fetched row returns
   // the old contents.
   always_ff @(posedge clk_i) begin
      if (ld_fire) begin
         mem_q[ld_addr_i] <= ld_row_i;
      end
   end

   always_comb begin
      state_d    = state_q;
      loaded_d   = loaded_q;
      addr_d     = addr_q;
      row_d      = row_q;
      row_addr_d = row_addr_q;

      if (ld_fire) begin
         loaded_d[ld_addr_i] = 1'b1;
      end

      case (state_q)
         IDLE: begin
            // Requests to unloaded rows simply wait here.
            if (req_valid_i && loaded_q[req_addr_i]) begin
               state_d = FETCH;
               addr_d  = req_addr_i;
            end
         end
         FETCH: begin
            state_d    = RESP;
            row_d      = mem_q[addr_q];
            row_addr_d = addr_q;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Flush overrides load, request and fetch; returned row is kept.
      if (flush_i) begin
         state_d    = IDLE;
         loaded_d   = '0;
         addr_d     = addr_q;
         row_d      = row_q;
         row_addr_d = row_addr_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         loaded_q   <= '0;
         addr_q     <= '0;
         row_q      <= '0;
         row_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         loaded_q   <= loaded_d;
         addr_q     <= addr_d;
         row_q      <= row_d;
         row_addr_q <= row_addr_d;
      end
   end

endmodule

// File: tb/tb_mat_row_server.sv
module tb_mat_row_server;

   localparam int SIZE   = 16;
   localparam int ELEM_W = 128;
   localparam int AW     = 4;
   localparam int ROW_W  = SIZE * ELEM_W;

   logic              clk = 1'b0;
   logic              rst_ni = 1'b0;
   logic [ROW_W-1:0]  ld_row_i = '0;
   logic [AW-1:0]     ld_addr_i = '0;
   logic              ld_valid_i = 1'b0;
   logic              ld_ready_o;
   logic [AW-1:0]     req_addr_i = '0;
   logic              req_valid_i = 1'b0;
   logic [ROW_W-1:0]  mat_row_o;
   logic [AW-1:0]     mat_row_addr_o;
   logic              mat_row_valid_o;
   logic [SIZE-1:0]   loaded_o;
   logic              flush_i = 1'b0;
   logic              busy_o;

   always #5 clk = ~clk;

   mat_row_server #(.SIZE(SIZE), .ELEM_W(ELEM_W), .AW(AW)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_ni),
      .ld_row_i       (ld_row_i),
      .ld_addr_i      (ld_addr_i),
      .ld_valid_i     (ld_valid_i),
      .ld_ready_o     (ld_ready_o),
      .req_addr_i     (req_addr_i),
      .req_valid_i    (req_valid_i),
      .mat_row_o      (mat_row_o),
      .mat_row_addr_o (mat_row_addr_o),
      .mat_row_valid_o(mat_row_valid_o),
      .loaded_o       (loaded_o),
      .flush_i        (flush_i),
      .busy_o         (busy_o)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: what each row should contain and which rows are loaded.
   logic [ROW_W-1:0] ref_mem [SIZE];
   logic [SIZE-1:0]  ref_loaded = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_row(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
      int unsigned bad = 0;
      logic [ELEM_W-1:0] eo, ee;
      for (int e = SIZE - 1; e >= 0; e--)
         if (obs[e*ELEM_W +: ELEM_W] !== exp[e*ELEM_W +: ELEM_W]) bad = e;
      eo = obs[bad*ELEM_W +: ELEM_W];
      ee = exp[bad*ELEM_W +: ELEM_W];
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: element %0d observed %h expected %h", tag, bad, eo, ee);
      end
   endtask

   function automatic logic [ROW_W-1:0] real_row(input logic [63:0] v);
      logic [ROW_W-1:0] r = '0;
      for (int e = 0; e < SIZE; e++) r[e*ELEM_W +: 64] = v;
      return r;
   endfunction

   function automatic logic [ROW_W-1:0] rand_row();
      logic [ROW_W-1:0] r;
      for (int w = 0; w < ROW_W / 32; w++) r[w*32 +: 32] = $urandom();
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [AW-1:0] a, input logic [ROW_W-1:0] d);
      ld_addr_i  = a;
      ld_row_i   = d;
      ld_valid_i = 1'b1;
      tick();
      ld_valid_i = 1'b0;
      ref_mem[a]    = d;
      ref_loaded[a] = 1'b1;
   endtask

   task automatic wait_valid(output int n, output logic got);
      n   = 0;
      got = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         n++;
         if (mat_row_valid_o === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
   endtask

   task automatic request(input logic [AW-1:0] a, input string tag);
      int   n;
      logic got;
      req_addr_i  = a;
      req_valid_i = 1'b1;
      wait_valid(n, got);
      req_valid_i = 1'b0;
      chk({tag, " got response"}, 64'(got), 64'd1);
      if (got) begin
         chk({tag, " latency"}, 64'(n), 64'd2);
         chk({tag, " addr"}, 64'(mat_row_addr_o), 64'(a));
         chk_row({tag, " row"}, mat_row_o, ref_mem[a]);
      end
      tick();
      chk({tag, " valid drop"}, 64'(mat_row_valid_o), 64'd0);
   endtask

   initial begin
      int               n;
      logic             got;
      logic [ROW_W-1:0] x, y, prev_row;
      logic [AW-1:0]    prev_addr, a, b;

      // Reset state
      repeat (3) tick();
      chk("rst loaded", 64'(loaded_o), 64'd0);
      chk("rst valid", 64'(mat_row_valid_o), 64'd0);
      chk("rst busy", 64'(busy_o), 64'd0);
      chk("rst addr", 64'(mat_row_addr_o), 64'd0);
      chk_row("rst row", mat_row_o, '0);
      rst_ni = 1'b1;

      // Request to an unloaded row stalls until it is loaded
      req_addr_i  = 4'd3;
      req_valid_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("stall valid", 64'(mat_row_valid_o), 64'd0);
      end
      chk("stall busy", 64'(busy_o), 64'd0);
      x = '0;
      for (int i = 0; i < ROW_W / 8; i++) x[i*8 +: 8] = 8'hA5;
      do_load(4'd3, x);
      chk("stall post-load valid", 64'(mat_row_valid_o), 64'd0);
      tick();
      chk("stall fetch valid", 64'(mat_row_valid_o), 64'd0);
      tick();
      chk("stall resp valid", 64'(mat_row_valid_o), 64'd1);
      chk("stall resp addr", 64'(mat_row_addr_o), 64'd3);
      chk_row("stall resp row", mat_row_o, ref_mem[3]);
      req_valid_i = 1'b0;
      tick();

      // Rows 0..15 with real part = row index; request row 5
      for (int r = 0; r < SIZE; r++) do_load(AW'(r), real_row(64'(r)));
      chk("load all bitmap", 64'(loaded_o), 64'hFFFF);
      req_addr_i  = 4'd5;
      req_valid_i = 1'b1;
      tick();
      chk("r5 fetch busy", 64'(busy_o), 64'd1);
      chk("r5 fetch valid", 64'(mat_row_valid_o), 64'd0);
      tick();
      req_valid_i = 1'b0;
      chk("r5 resp busy", 64'(busy_o), 64'd1);
      chk("r5 resp valid", 64'(mat_row_valid_o), 64'd1);
      chk("r5 resp addr", 64'(mat_row_addr_o), 64'd5);
      chk_row("r5 resp row", mat_row_o, real_row(64'd5));
      tick();
      chk("r5 idle busy", 64'(busy_o), 64'd0);
      chk("r5 idle valid", 64'(mat_row_valid_o), 64'd0);
      chk_row("r5 row held", mat_row_o, real_row(64'd5));
      chk("r5 addr held", 64'(mat_row_addr_o), 64'd5);

      // Sweep with random rows, then a held request that is re-served
      for (int r = 0; r < SIZE; r++) do_load(AW'(r), rand_row());
      req_addr_i  = '0;
      req_valid_i = 1'b1;
      for (int i = 0; i < SIZE; i++) begin
         wait_valid(n, got);
         chk("sweep got response", 64'(got), 64'd1);
         chk("sweep spacing", 64'(n), (i == 0) ? 64'd2 : 64'd3);
         chk("sweep addr", 64'(mat_row_addr_o), 64'(i));
         chk_row("sweep row", mat_row_o, ref_mem[i]);
         if (i < SIZE - 1) req_addr_i = AW'(i + 1);
      end
      wait_valid(n, got);
      req_valid_i = 1'b0;
      chk("dup got response", 64'(got), 64'd1);
      chk("dup spacing", 64'(n), 64'd3);
      chk("dup addr", 64'(mat_row_addr_o), 64'd15);
      tick();

      // Load on the FETCH edge does not affect the response
      x = rand_row();
      y = rand_row();
      do_load(4'd7, x);
      req_addr_i  = 4'd7;
      req_valid_i = 1'b1;
      tick();
      chk("rbw fetch busy", 64'(busy_o), 64'd1);
      ld_addr_i   = 4'd7;
      ld_row_i    = y;
      ld_valid_i  = 1'b1;
      tick();
      ld_valid_i  = 1'b0;
      req_valid_i = 1'b0;
      chk("rbw valid", 64'(mat_row_valid_o), 64'd1);
      chk_row("rbw old row", mat_row_o, x);
      ref_mem[7] = y;
      tick();
      request(4'd7, "rbw repeat");

      // Flush in FETCH with a same-cycle load to row 2
      prev_row  = mat_row_o;
      prev_addr = mat_row_addr_o;
      req_addr_i  = 4'd4;
      req_valid_i = 1'b1;
      tick();
      chk("flush fetch busy", 64'(busy_o), 64'd1);
      flush_i    = 1'b1;
      ld_addr_i  = 4'd2;
      ld_row_i   = rand_row();
      ld_valid_i = 1'b1;
      #1;
      chk("flush ld_ready", 64'(ld_ready_o), 64'd0);
      tick();
      flush_i    = 1'b0;
      ld_valid_i = 1'b0;
      ref_loaded = '0;
      chk("flush valid", 64'(mat_row_valid_o), 64'd0);
      chk("flush busy", 64'(busy_o), 64'd0);
      chk("flush loaded", 64'(loaded_o), 64'd0);
      chk_row("flush row held", mat_row_o, prev_row);
      chk("flush addr held", 64'(mat_row_addr_o), 64'(prev_addr));
      tick();
      chk("flush no resp", 64'(mat_row_valid_o), 64'd0);
      chk("flush stall busy", 64'(busy_o), 64'd0);
      req_valid_i = 1'b0;

      // Random loads and requests
      for (int it = 0; it < 12; it++) begin
         a = AW'($urandom_range(0, SIZE - 1));
         do_load(a, rand_row());
         chk("rand loaded", 64'(loaded_o), 64'(ref_loaded));
         b = AW'($urandom_range(0, SIZE - 1));
         while (!ref_loaded[b]) b = AW'($urandom_range(0, SIZE - 1));
         request(b, "rand req");
      end

      // Asynchronous reset while in RESP
      req_addr_i  = 4'd9;
      req_valid_i = 1'b1;
      if (!ref_loaded[9]) do_load(4'd9, rand_row());
      wait_valid(n, got);
      req_valid_i = 1'b0;
      chk("areset reached resp", 64'(got), 64'd1);
      #2;
      rst_ni = 1'b0;
      #1;
      ref_loaded = '0;
      chk("areset valid", 64'(mat_row_valid_o), 64'd0);
      chk("areset busy", 64'(busy_o), 64'd0);
      chk("areset loaded", 64'(loaded_o), 64'd0);
      chk("areset addr", 64'(mat_row_addr_o), 64'd0);
      tick();
      rst_ni = 1'b1;
      tick();
      chk("areset after release valid", 64'(mat_row_valid_o), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
